// File: rtl/dms_scan_ctrl_pkg.sv
// Shared constants for the dms scan controller: FSM encodings, last slot address and
// hold-counter defaults.
package dms_scan_ctrl_pkg;

  localparam logic [1:0] DMS_S_IDLE  = 2'd0;
  localparam logic [1:0] DMS_S_DRIVE = 2'd1;
  localparam logic [1:0] DMS_S_DONE  = 2'd2;

  localparam logic [1:0] DMS_LAST_ADR = 2'd3;

  localparam int unsigned DMS_HOLD_DEFAULT = 20;
  localparam int unsigned DMS_CNT_W        = 8;

endpackage

// File: rtl/dms_hold_timer.sv
// Clear/enable slot-hold counter; expire is high on the last cycle of a slot and the
// count wraps back to zero on the following edge.
module dms_hold_timer
  import dms_scan_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DMS_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [DMS_CNT_W-1:0] LastCount = DMS_CNT_W'(HOLD_CYCLES - 1);

  logic [DMS_CNT_W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + DMS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dms_scan_ctrl.sv
// Drives the dms demux: captures a 4-bit word on start and presents word[adr] for
// HOLD_CYCLES cycles per address 0..3, then pulses done. All outputs are registered.
module dms_scan_ctrl
  import dms_scan_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DMS_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] word,
  output logic       line,
  output logic [1:0] adr,
  output logic       slot_valid,
  output logic       busy,
  output logic       done
);

  logic [1:0] state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [1:0] adr_q, adr_d;
  logic       line_q, line_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_clr, tmr_en, tmr_expire;
  logic [1:0] adr_nxt;

  dms_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  assign adr_nxt = adr_q + 2'd1;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    adr_d   = adr_q;
    line_d  = line_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      DMS_S_DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          if (adr_q == DMS_LAST_ADR) begin
            state_d = DMS_S_DONE;
            adr_d   = 2'd0;
            line_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            adr_d  = adr_nxt;
            line_d = word_q[adr_nxt];
          end
        end
      end
      default: begin
        // IDLE and DONE both accept start; DONE gives back-to-back scans.
        adr_d   = 2'd0;
        valid_d = start;
        busy_d  = start;
        if (start) begin
          state_d = DMS_S_DRIVE;
          word_d  = word;
          line_d  = word[0];
          tmr_clr = 1'b1;
        end else begin
          state_d = DMS_S_IDLE;
          line_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMS_S_IDLE;
      word_q  <= '0;
      adr_q   <= '0;
      line_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      adr_q   <= adr_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign line       = line_q;
  assign adr        = adr_q;
  assign slot_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dms_scan_ctrl.sv
// Directed bench: four controllers (H=20,2,4,1) share clock/reset; u20 feeds a dms demux.
module tb_dms_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] start = 4'b0;
  logic [3:0] word [4];

  logic       line [4];
  logic [1:0] adr [4];
  logic       slot_valid [4];
  logic       busy [4];
  logic       done [4];
  logic [3:0] dms_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dms_scan_ctrl #(.HOLD_CYCLES(20)) u20 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .word(word[0]), .line(line[0]),
    .adr(adr[0]), .slot_valid(slot_valid[0]), .busy(busy[0]), .done(done[0]));
  dms_scan_ctrl #(.HOLD_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .word(word[1]), .line(line[1]),
    .adr(adr[1]), .slot_valid(slot_valid[1]), .busy(busy[1]), .done(done[1]));
  dms_scan_ctrl #(.HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .word(word[2]), .line(line[2]),
    .adr(adr[2]), .slot_valid(slot_valid[2]), .busy(busy[2]), .done(done[2]));
  dms_scan_ctrl #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .word(word[3]), .line(line[3]),
    .adr(adr[3]), .slot_valid(slot_valid[3]), .busy(busy[3]), .done(done[3]));

  // Behavioural 1-to-4 demux standing in for dms.
  always_comb begin
    dms_data = 4'b0;
    dms_data[adr[0]] = line[0];
  end

  function automatic logic [5:0] obs(input int k);
    return {line[k], adr[k], slot_valid[k], busy[k], done[k]};
  endfunction

  // Expected {line, adr, slot_valid, busy, done} for cycle n after start was sampled.
  function automatic logic [5:0] exp_at(input int h, input logic [3:0] w, input int n);
    int s;
    if (n >= 1 && n <= 4 * h) begin
      s = (n - 1) / h;
      return {w[s], 2'(s), 1'b1, 1'b1, 1'b0};
    end
    if (n == 4 * h + 1) return 6'b000001;
    return 6'b000000;
  endfunction

  task automatic chk(input string tag, input int n, input logic [5:0] o, input logic [5:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, n, o, e);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int n);
    for (int k = 0; k < 4; k++) chk(tag, n, obs(k), 6'b0);
  endtask

  initial begin
    logic [3:0] exp_data;
    for (int k = 0; k < 4; k++) word[k] = 4'h0;

    // Reset then idle
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_all_zero("reset", n);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk_all_zero("idle", n);
    end

    // Basic scan H=20, word 1010, with demux outputs
    @(negedge clk);
    start[0] = 1'b1;
    word[0]  = 4'b1010;
    for (int n = 1; n <= 82; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 5) word[0] = 4'b0101;
      chk("basic", n, obs(0), exp_at(20, 4'b1010, n));
      exp_data = 4'b0;
      if (n >= 21 && n <= 40) exp_data = 4'b0010;
      if (n >= 61 && n <= 80) exp_data = 4'b1000;
      chk("demux", n, {2'b0, dms_data}, {2'b0, exp_data});
    end

    // Back-to-back H=2: 4'hF then 4'h1 accepted in the DONE cycle
    @(negedge clk);
    start[1] = 1'b1;
    word[1]  = 4'hF;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      start[1] = 1'b0;
      if (n == 3) word[1] = 4'h0;
      chk("b2b", n, obs(1), (n <= 9) ? exp_at(2, 4'hF, n) : exp_at(2, 4'h1, n - 9));
      if (n == 9) begin
        start[1] = 1'b1;
        word[1]  = 4'h1;
      end
    end

    // Ignored start mid-scan, H=4
    @(negedge clk);
    start[2] = 1'b1;
    word[2]  = 4'hF;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      start[2] = 1'b0;
      chk("ignore", n, obs(2), exp_at(4, 4'hF, n));
      if (n == 6) begin
        start[2] = 1'b1;
        word[2]  = 4'h0;
      end
    end

    // Minimum hold H=1, word 0110
    @(negedge clk);
    start[3] = 1'b1;
    word[3]  = 4'b0110;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start[3] = 1'b0;
      chk("h1", n, obs(3), exp_at(1, 4'b0110, n));
    end

    // Reset mid-DRIVE at cycle 30 (adr=1, line=1)
    @(negedge clk);
    start[0] = 1'b1;
    word[0]  = 4'b1010;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      chk("pre_rst", n, obs(0), exp_at(20, 4'b1010, n));
    end
    #1 rst_n = 1'b0;
    #1 chk("async_rst", 30, obs(0), 6'b0);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk_all_zero("in_rst", n);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk_all_zero("post_rst", n);
    end
    start[0] = 1'b1;
    word[0]  = 4'b0011;
    for (int n = 1; n <= 82; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      chk("rescan", n, obs(0), exp_at(20, 4'b0011, n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
